// File: rtl/serial_word_comparator.sv
// Serial unsigned magnitude comparator: evaluates 2-bit slices MSB-first.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN stops at the first unequal slice.
//   state     | meaning
//   S_IDLE    | waiting for start, operands captured on the accepting edge
//   S_COMPARE | one slice per cycle, operands shifted left by 2 each step
//   S_DONE    | first cycle settles, second cycle pulses done
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             Greater,
    output logic             Equal,
    output logic             Less
);
    localparam int NSL   = WIDTH / 2;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSL - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_found;
    logic             r_gt;
    logic             r_busy;
    logic             r_done;
    logic             r_greater;
    logic             r_equal;
    logic             r_less;

    logic [1:0] w_sa;
    logic [1:0] w_sb;
    logic       w_slice_ne;
    logic       w_slice_gt;
    logic       w_found_final;
    logic       w_gt_final;
    logic       w_last;

    assign w_sa          = r_a[WIDTH-1 -: 2];
    assign w_sb          = r_b[WIDTH-1 -: 2];
    assign w_slice_ne    = (w_sa != w_sb);
    assign w_slice_gt    = (w_sa > w_sb);
    // the first unequal slice decides; later slices cannot change the verdict
    assign w_found_final = r_found | w_slice_ne;
    assign w_gt_final    = r_found ? r_gt : w_slice_gt;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign w_last        = (r_idx == '0) | w_slice_ne;
`else
    assign w_last        = (r_idx == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_found   <= 1'b0;
            r_gt      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_greater <= 1'b0;
            r_equal   <= 1'b0;
            r_less    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_idx   <= IDX_TOP;
                        r_found <= 1'b0;
                        r_gt    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_last) begin
                        r_greater <= w_found_final & w_gt_final;
                        r_less    <= w_found_final & ~w_gt_final;
                        r_equal   <= ~w_found_final;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_a     <= r_a << 2;
                        r_b     <= r_b << 2;
                        r_found <= w_found_final;
                        r_gt    <= w_gt_final;
                    end
                end
                S_DONE: begin
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign Greater = r_greater;
    assign Equal   = r_equal;
    assign Less    = r_less;

endmodule

// File: doc/serial_word_comparator.md
SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; even, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a comparison; sampled only in IDLE.
REQ-005 SHALL have port in1  input  WIDTH  first operand; captured on the accepting edge.
REQ-006 SHALL have port in2  input  WIDTH  second operand; captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while in COMPARE or DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port Greater  output  1  registered result, in1 > in2 (unsigned).
REQ-010 SHALL have port Equal  output  1  registered result, in1 == in2.
REQ-011 SHALL have port Less  output  1  registered result, in1 < in2 (unsigned).

Function
REQ-012 SHALL implement states IDLE, COMPARE, DONE.
REQ-013 SHALL, in IDLE with start=1 at an edge, capture in1 and in2, set slice index to WIDTH/2-1 and enter COMPARE.
REQ-014 SHALL, in IDLE with start=0, stay in IDLE.
REQ-015 SHALL evaluate one 2-bit slice per COMPARE cycle, MSB-first: bits [2i+1:2i] of the captured operands, unsigned.
REQ-016 SHALL take the final result from the first unequal slice: its Greater or Less; Equal only if all slices are equal.
REQ-017 SHALL decrement the slice index after each equal slice; the index SHALL never wrap below 0.
REQ-018 SHALL, after the edge that ends the last evaluated slice, register Greater/Equal/Less and enter DONE.
REQ-019 SHALL keep exactly one of Greater/Equal/Less high after any completed comparison.
REQ-020 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE.
REQ-021 SHALL have a latency of N+1 edges from the accepting edge to the cycle done is high, where N is the number of slices evaluated.
REQ-022 SHALL ignore start while in COMPARE or DONE; such a start SHALL NOT be queued.
REQ-023 SHALL be unaffected by changes on in1 or in2 after the accepting edge.
REQ-024 SHALL hold Greater/Equal/Less from the accepting edge until they are overwritten at the completion of the next comparison.

Reset
REQ-025 SHALL, while rst_n=0, force state to IDLE, busy=0, done=0, Greater=0, Equal=0, Less=0, and clear the captured operands and the slice index, regardless of clk.
REQ-026 SHALL abort an in-progress comparison on reset; no done pulse SHALL follow the abort.
REQ-027 SHALL accept a start on the first rising edge at which rst_n=1.

Configuration
REQ-028 SHALL support the macro SERIAL_CMP_EARLY_EXIT_EN.
REQ-029 SHALL, when SERIAL_CMP_EARLY_EXIT_EN is defined, go to DONE right after the first unequal slice, giving N = slices up to and including that slice.
REQ-030 SHALL, when SERIAL_CMP_EARLY_EXIT_EN is not defined, always evaluate all WIDTH/2 slices, giving a constant latency of WIDTH/2+1 edges; the result SHALL be unchanged.

Verification (WIDTH=8)
REQ-031 SHALL cover: in1=0xC5, in2=0x35, start pulse -> Greater=1, Equal=0, Less=0; done 2 edges after accept with EARLY_EXIT_EN, 5 edges without.
REQ-032 SHALL cover: in1=0xA5, in2=0xA5 -> Equal=1; done 5 edges after accept in both configurations.
REQ-033 SHALL cover: in1=0x12, in2=0x13 -> Less=1; done 5 edges after accept in both configurations.
REQ-034 SHALL cover: start with 0x40 vs 0x80; change in1/in2 and pulse start again while busy=1 -> one done only, Less=1, second start ignored.
REQ-035 SHALL cover: rst_n low for one cycle mid-COMPARE -> all outputs 0 at once, no done; new start 0xFF vs 0x00 -> Greater=1.
REQ-036 SHALL cover: back-to-back start held high continuously -> a new accept in each IDLE cycle after done; busy low only in those IDLE cycles.
